// File: rtl/seq_det_pkg.sv
// Shared constants, types and the round-robin pick function for the seq_det_arbiter block.
// The optional per-channel match counters are enabled with SEQ_MATCH_COUNT_EN.
package seq_det_pkg;

  localparam int PLEN_DEF = 4;
  localparam logic [PLEN_DEF-1:0] PATTERN_DEF = 4'b1011;
  localparam int CNT_W = 8;
  localparam int MAX_N = 16;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping at n (n <= MAX_N, ptr < n).
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                       input logic [IDX_W-1:0] ptr,
                                       input int n);
    rr_pick_t res;
    logic [IDX_W:0] c;
    res = '0;
    for (int k = 0; k < MAX_N; k++) begin
      c = {1'b0, ptr} + (IDX_W+1)'(k);
      if (c >= (IDX_W+1)'(n)) c = c - (IDX_W+1)'(n);
      if ((k < n) && !res.found && req[c[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = c[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// One-hot round-robin arbiter: combinational pick from the request vector and a
// registered rotating priority pointer that advances past each winner.
module seq_det_rr_arb
  import seq_det_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] winner_o,
  output logic                 found_o
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N-1);

  logic [PW-1:0] ptr_q, ptr_d;
  rr_pick_t      pick;

  always_comb begin
    pick = rr_pick(MAX_N'(req_i), IDX_W'(ptr_q), N);
  end

  assign found_o  = pick.found;
  assign winner_o = pick.idx[PW-1:0];

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = pick.found && (pick.idx == IDX_W'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (pick.found) ptr_d = (winner_o == LAST) ? '0 : winner_o + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin shared serial pattern detector for N bit-serial channels.
// Define SEQ_MATCH_COUNT_EN to add per-channel saturating match counters on match_cnt.
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int N = 4,
  parameter int PLEN = PLEN_DEF,
  parameter logic [PLEN-1:0] PATTERN = PATTERN_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         bit_in,
  input  logic [N-1:0]         clear_ch,
  output logic [N-1:0]         grant,
  output logic                 match_valid,
  output logic [$clog2(N)-1:0] match_ch
`ifdef SEQ_MATCH_COUNT_EN
  ,
  output logic [N*CNT_W-1:0]   match_cnt
`endif
);

  localparam int PW = $clog2(N);
  localparam int FW = $clog2(PLEN+1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PLEN);

  function automatic logic [FW-1:0] fill_inc(input logic [FW-1:0] f);
    return (f == FILL_FULL) ? f : f + 1'b1;
  endfunction

  logic [N-1:0]    eff_req;
  logic [PW-1:0]   win;
  logic            win_vld;

  logic [PLEN-1:0] hist_q [N];
  logic [PLEN-1:0] hist_d [N];
  logic [FW-1:0]   fill_q [N];
  logic [FW-1:0]   fill_d [N];
  logic [PLEN-1:0] new_hist;
  logic [FW-1:0]   new_fill;
  logic            hit;

  logic            match_valid_q;
  logic [PW-1:0]   match_ch_q;

  // Clear beats request; holding reset also suppresses grant combinationally.
  assign eff_req = req & ~clear_ch & {N{reset_n}};

  seq_det_rr_arb #(.N(N)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (eff_req),
    .grant_o  (grant),
    .winner_o (win),
    .found_o  (win_vld)
  );

  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    new_hist = '0;
    new_fill = '0;
    hit      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (clear_ch[i]) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end
    end
    if (win_vld) begin
      new_hist    = {hist_q[win][PLEN-2:0], bit_in[win]};
      new_fill    = fill_inc(fill_q[win]);
      hist_d[win] = new_hist;
      fill_d[win] = new_fill;
      // Fill gating keeps an all-zero PATTERN from firing on reset history.
      hit         = (new_hist == PATTERN) && (new_fill == FILL_FULL);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      match_valid_q <= hit;
      if (hit) match_ch_q <= win;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;

`ifdef SEQ_MATCH_COUNT_EN
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (clear_ch[i]) cnt_d[i] = '0;
    end
    if (hit) cnt_d[win] = cnt_inc(cnt_q[win]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < N; i++) match_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter (N=4, PATTERN=1011); match counter
// scenario runs only when SEQ_MATCH_COUNT_EN is defined.
module tb_seq_det_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] bit_in = '0;
  logic [3:0] clear_ch = '0;
  logic [3:0] grant;
  logic       match_valid;
  logic [1:0] match_ch;
`ifdef SEQ_MATCH_COUNT_EN
  logic [31:0] match_cnt;
`endif

  always #5 clk = ~clk;

  seq_det_arbiter #(.N(4), .PLEN(4), .PATTERN(4'b1011)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .bit_in      (bit_in),
    .clear_ch    (clear_ch),
    .grant       (grant),
    .match_valid (match_valid),
    .match_ch    (match_ch)
`ifdef SEQ_MATCH_COUNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int hits = 0;
  int sb[$];

  int         m_ptr;
  logic [3:0] m_hist [4];
  int         m_fill [4];
  int         m_cnt  [4];

  function automatic logic [3:0] m_grant(input logic [3:0] r, input logic [3:0] c);
    logic [3:0] eff;
    logic [3:0] one;
    int idx;
    eff = r & ~c;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (eff[idx]) return one << idx;
    end
    return 4'b0000;
  endfunction

  task automatic m_reset();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = '0;
      m_fill[i] = 0;
      m_cnt[i]  = 0;
    end
    sb.delete();
  endtask

  task automatic m_apply(input logic [3:0] b, input logic [3:0] c, input logic [3:0] g,
                         output bit hit_o, output int ch_o);
    hit_o = 1'b0;
    ch_o  = 0;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) begin
        m_hist[i] = '0;
        m_fill[i] = 0;
        m_cnt[i]  = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        ch_o = i;
        m_hist[i] = {m_hist[i][2:0], b[i]};
        if (m_fill[i] < 4) m_fill[i]++;
        hit_o = (m_hist[i] == 4'b1011) && (m_fill[i] == 4);
        if (hit_o && m_cnt[i] < 255) m_cnt[i]++;
        m_ptr = (i + 1) % 4;
      end
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c,
                       output logic [3:0] g_obs, output logic [3:0] g_exp);
    bit exp_m;
    int exp_ch;
    req = r;
    bit_in = b;
    clear_ch = c;
    #3;
    g_obs = grant;
    g_exp = m_grant(r, c);
    m_apply(b, c, g_exp, exp_m, exp_ch);
    if (exp_m) sb.push_back(exp_ch);
    @(posedge clk);
    #1;
    if (match_valid === 1'b1) hits++;
    if (match_valid === 1'b1 || exp_m) begin
      checks++;
      if (match_valid !== exp_m) begin
        errors++;
        $display("FAIL sb_match_valid got %b expected %b", match_valid, exp_m);
      end else if (match_ch !== 2'(sb[0])) begin
        errors++;
        $display("FAIL sb_match_ch got %0d expected %0d", match_ch, sb[0]);
      end
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    bit_in = '0;
    clear_ch = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'hF;
    bit_in = 4'hF;
    clear_ch = '0;
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b expected 0000", grant); end
    checks++;
    if (match_valid !== 1'b0) begin errors++; $display("FAIL reset_match_valid got %b expected 0", match_valid); end
    checks++;
    if (match_ch !== 2'd0) begin errors++; $display("FAIL reset_match_ch got %0d expected 0", match_ch); end
`ifdef SEQ_MATCH_COUNT_EN
    checks++;
    if (match_cnt !== 32'd0) begin errors++; $display("FAIL reset_match_cnt got %h expected 0", match_cnt); end
`endif
    reset_n = 1'b1;
    #2;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b expected 0001", grant); end
  endtask

  task automatic test_single();
    int s[9] = '{0, 0, 1, 0, 1, 1, 0, 1, 1};
    logic [3:0] go, ge;
    int h0;
    do_reset();
    h0 = hits;
    for (int k = 0; k < 9; k++) begin
      drive(4'b0001, {3'b000, s[k][0]}, 4'b0000, go, ge);
      checks++;
      if (go !== 4'b0001) begin errors++; $display("FAIL single_grant bit %0d got %b expected 0001", k, go); end
    end
    checks++;
    if (hits - h0 != 2) begin errors++; $display("FAIL single_overlap_count got %0d expected 2", hits - h0); end
  endtask

  task automatic test_rotate();
    int p[4] = '{1, 0, 1, 1};
    int idx;
    logic [3:0] go, ge, b;
    int h0;
    do_reset();
    h0 = hits;
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      b = (idx < 4 && p[idx] == 1) ? 4'b0100 : 4'b0000;
      drive(4'hF, b, 4'b0000, go, ge);
      checks++;
      if (go !== (4'b0001 << (k % 4))) begin
        errors++;
        $display("FAIL rotate_grant cycle %0d got %b expected %b", k, go, 4'b0001 << (k % 4));
      end
      if (ge[2]) idx++;
    end
    checks++;
    if (hits - h0 != 1) begin errors++; $display("FAIL rotate_match_count got %0d expected 1", hits - h0); end
  endtask

  task automatic test_clear();
    int pre[3] = '{1, 0, 1};
    int post[3] = '{0, 1, 1};
    logic [3:0] go, ge;
    int h0;
    do_reset();
    for (int k = 0; k < 3; k++) drive(4'b0010, {2'b00, pre[k][0], 1'b0}, 4'b0000, go, ge);
    h0 = hits;
    drive(4'b0011, 4'b0010, 4'b0010, go, ge);
    checks++;
    if (go !== 4'b0001) begin errors++; $display("FAIL clear_grant got %b expected 0001", go); end
    drive(4'b0010, 4'b0010, 4'b0000, go, ge);
    checks++;
    if (go !== 4'b0010) begin errors++; $display("FAIL clear_next_grant got %b expected 0010", go); end
    checks++;
    if (hits != h0) begin errors++; $display("FAIL clear_no_match got %0d expected 0", hits - h0); end
    for (int k = 0; k < 3; k++) drive(4'b0010, {2'b00, post[k][0], 1'b0}, 4'b0000, go, ge);
    checks++;
    if (hits - h0 != 1) begin errors++; $display("FAIL clear_restart_match got %0d expected 1", hits - h0); end
  endtask

  task automatic test_reset_mid();
    int p[4] = '{1, 0, 1, 1};
    int f[6] = '{0, 1, 1, 0, 1, 1};
    logic [3:0] go, ge;
    int h0;
    do_reset();
    for (int k = 0; k < 4; k++) drive(4'b0001, {3'b000, p[k][0]}, 4'b0000, go, ge);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (match_valid !== 1'b0) begin errors++; $display("FAIL midreset_match_valid got %b expected 0", match_valid); end
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL midreset_grant got %b expected 0000", grant); end
    do_reset();
    h0 = hits;
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, {3'b000, f[k][0]}, 4'b0000, go, ge);
      checks++;
      if (go !== 4'b0001) begin errors++; $display("FAIL midreset_grant_after bit %0d got %b expected 0001", k, go); end
      if (k == 2) begin
        checks++;
        if (hits != h0) begin errors++; $display("FAIL midreset_history_lost got %0d expected 0", hits - h0); end
      end
    end
    checks++;
    if (hits - h0 != 1) begin errors++; $display("FAIL midreset_fresh_match got %0d expected 1", hits - h0); end
  endtask

  task automatic test_starvation();
    int cnt[4] = '{0, 0, 0, 0};
    logic [3:0] go, ge;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(4'hF, 4'h0, 4'h0, go, ge);
      checks++;
      if ($countones(go) != 1) begin errors++; $display("FAIL starve_onehot cycle %0d got %b expected one-hot", k, go); end
      for (int i = 0; i < 4; i++) if (go[i] === 1'b1) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 10) begin errors++; $display("FAIL starve_count ch%0d got %0d expected 10", i, cnt[i]); end
    end
  endtask

`ifdef SEQ_MATCH_COUNT_EN
  task automatic test_count();
    int p[4] = '{1, 0, 1, 1};
    logic [3:0] go, ge;
    logic b3;
    int h0;
    do_reset();
    h0 = hits;
    for (int k = 0; k <= 900; k++) begin
      if (k < 4) b3 = p[k][0];
      else       b3 = ((k - 4) % 3 == 0) ? 1'b0 : 1'b1;
      drive(4'b1000, {b3, 3'b000}, 4'b0000, go, ge);
    end
    checks++;
    if (hits - h0 != 300) begin errors++; $display("FAIL count_matches got %0d expected 300", hits - h0); end
    checks++;
    if (match_cnt !== {8'd255, 24'd0}) begin errors++; $display("FAIL count_saturate got %h expected ff000000", match_cnt); end
    drive(4'b1000, 4'b1000, 4'b1000, go, ge);
    checks++;
    if (go !== 4'b0000) begin errors++; $display("FAIL count_clear_grant got %b expected 0000", go); end
    checks++;
    if (match_cnt !== 32'd0) begin errors++; $display("FAIL count_clear got %h expected 0", match_cnt); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_rotate();
    test_clear();
    test_reset_mid();
    test_starvation();
`ifdef SEQ_MATCH_COUNT_EN
    test_count();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drained got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
